// File: rtl/out_sel_pipe_if.sv
// Handshake and result bus for out_sel_pipe: allocation vectors in, encoded ports and flags out.
interface out_sel_pipe_if #(
    parameter int NUM_PORT     = 5,
    parameter int LOG_NUM_PORT = 3,
    parameter int NUM_CH       = 4
);
    logic [NUM_CH*NUM_PORT-1:0]     alloc;
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_CH*LOG_NUM_PORT-1:0] outSel;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_CH-1:0]              none_err;
    logic [NUM_CH-1:0]              multi_err;
    logic [NUM_CH-1:0]              conflict;
    logic [15:0]                    err_cnt;

    modport master (
        output alloc, in_valid, out_ready,
        input  in_ready, outSel, out_valid, none_err, multi_err, conflict, err_cnt
    );

    modport slave (
        input  alloc, in_valid, out_ready,
        output in_ready, outSel, out_valid, none_err, multi_err, conflict, err_cnt
    );
endinterface

// File: rtl/out_sel_pipe.sv
// Per-channel one-hot allocation to encoded output port, with error flags and a
// single-entry valid/ready output register.
module out_sel_pipe #(
    parameter int NUM_PORT     = 5,
    parameter int LOG_NUM_PORT = 3,
    parameter int NUM_CH       = 4,
    parameter int MSB_FIRST    = 1
) (
    input  logic            clk,
    input  logic            reset,
    out_sel_pipe_if.slave   bus
);
    logic [NUM_CH-1:0][NUM_PORT-1:0]     ch_alloc;
    logic [NUM_CH-1:0][LOG_NUM_PORT-1:0] sel_d, sel_q;
    logic [NUM_CH-1:0]                   none_d, none_q;
    logic [NUM_CH-1:0]                   multi_d, multi_q;
    logic [NUM_CH-1:0]                   conf_d, conf_q;
    logic [15:0]                         err_cnt_d, err_cnt_q;
    logic                                valid_q;
    logic                                in_ready;
    logic                                accept;
    logic                                any_err;

    assign ch_alloc = bus.alloc;

    always_comb begin : encode
        logic hit;
        hit     = 1'b0;
        sel_d   = '0;
        none_d  = '0;
        multi_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            hit = 1'b0;
            // Scanning upward: MSB-first keeps overwriting, LSB-first keeps the first hit.
            for (int unsigned i = 0; i < NUM_PORT; i++) begin
                if (ch_alloc[c][i]) begin
                    if (MSB_FIRST != 0 || !hit) begin
                        sel_d[c] = LOG_NUM_PORT'(i);
                    end
                    if (hit) begin
                        multi_d[c] = 1'b1;
                    end
                    hit = 1'b1;
                end
            end
            none_d[c] = !hit;
        end
    end

    always_comb begin
        conf_d = '0;
        for (int unsigned c = 1; c < NUM_CH; c++) begin
            for (int unsigned j = 0; j < c; j++) begin
                if (!none_d[j] && !none_d[c] && sel_d[j] == sel_d[c]) begin
                    conf_d[c] = 1'b1;
                end
            end
        end
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign any_err  = |{none_d, multi_d, conf_d};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && any_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            sel_q     <= '0;
            none_q    <= '0;
            multi_q   <= '0;
            conf_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                sel_q   <= sel_d;
                none_q  <= none_d;
                multi_q <= multi_d;
                conf_q  <= conf_d;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.outSel    = sel_q;
    assign bus.none_err  = none_q;
    assign bus.multi_err = multi_q;
    assign bus.conflict  = conf_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_out_sel_pipe.sv
// Directed plus randomized checks of out_sel_pipe (MSB-first and LSB-first builds) against a reference model.
module tb_out_sel_pipe;
    localparam int NP = 5;
    localparam int LW = 3;
    localparam int NC = 4;

    typedef struct packed {
        logic          valid;
        logic [NC*LW-1:0] sel;
        logic [NC-1:0] none;
        logic [NC-1:0] multi;
        logic [NC-1:0] conf;
        logic [15:0]   cnt;
    } st_t;

    logic clk = 1'b0;
    logic reset;
    logic [NC*NP-1:0] a;
    logic iv;
    logic ordy;

    int vectors = 0;
    int miscompares = 0;
    st_t mh, ml;

    always #5 clk = ~clk;

    out_sel_pipe_if #(.NUM_PORT(NP), .LOG_NUM_PORT(LW), .NUM_CH(NC)) bus_h ();
    out_sel_pipe_if #(.NUM_PORT(NP), .LOG_NUM_PORT(LW), .NUM_CH(NC)) bus_l ();

    assign bus_h.alloc = a;
    assign bus_h.in_valid = iv;
    assign bus_h.out_ready = ordy;
    assign bus_l.alloc = a;
    assign bus_l.in_valid = iv;
    assign bus_l.out_ready = ordy;

    out_sel_pipe #(.NUM_PORT(NP), .LOG_NUM_PORT(LW), .NUM_CH(NC), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .bus(bus_h)
    );
    out_sel_pipe #(.NUM_PORT(NP), .LOG_NUM_PORT(LW), .NUM_CH(NC), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l)
    );

    function automatic st_t model_next(st_t s, bit msb, logic rst, logic [NC*NP-1:0] av,
                                       logic v_in, logic r_out);
        st_t n;
        bit claimed [NP];
        int v;
        int e;
        n = s;
        if (rst) begin
            n = '0;
            return n;
        end
        if (v_in && (!s.valid || r_out)) begin
            n.valid = 1'b1;
            n.sel = '0;
            n.none = '0;
            n.multi = '0;
            n.conf = '0;
            foreach (claimed[p]) claimed[p] = 1'b0;
            for (int c = 0; c < NC; c++) begin
                v = int'(av[c*NP +: NP]);
                if (v == 0) begin
                    e = 0;
                    n.none[c] = 1'b1;
                end else begin
                    e = msb ? $clog2(v + 1) - 1 : $clog2(v & -v);
                    n.multi[c] = ($countones(v) > 1);
                    n.conf[c] = claimed[e];
                    claimed[e] = 1'b1;
                end
                n.sel[c*LW +: LW] = e[LW-1:0];
            end
            if ((|n.none || |n.multi || |n.conf) && s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
        end else if (r_out) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(string n, st_t m, st_t o, logic ir);
        chk({n, ".out_valid"}, 32'(o.valid), 32'(m.valid));
        chk({n, ".outSel"}, 32'(o.sel), 32'(m.sel));
        chk({n, ".none_err"}, 32'(o.none), 32'(m.none));
        chk({n, ".multi_err"}, 32'(o.multi), 32'(m.multi));
        chk({n, ".conflict"}, 32'(o.conf), 32'(m.conf));
        chk({n, ".err_cnt"}, 32'(o.cnt), 32'(m.cnt));
        chk({n, ".in_ready"}, 32'(ir), 32'(!m.valid || ordy));
    endtask

    task automatic check_all();
        check_one("msb", mh, st_t'({bus_h.out_valid, bus_h.outSel, bus_h.none_err,
                  bus_h.multi_err, bus_h.conflict, bus_h.err_cnt}), bus_h.in_ready);
        check_one("lsb", ml, st_t'({bus_l.out_valid, bus_l.outSel, bus_l.none_err,
                  bus_l.multi_err, bus_l.conflict, bus_l.err_cnt}), bus_l.in_ready);
    endtask

    task automatic step();
        mh = model_next(mh, 1'b1, reset, a, iv, ordy);
        ml = model_next(ml, 1'b0, reset, a, iv, ordy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [NC*NP-1:0] rand_alloc();
        logic [NC*NP-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            case ($urandom_range(0, 3))
                0: r[c*NP +: NP] = '0;
                1, 2: r[c*NP +: NP] = NP'(1 << $urandom_range(0, NP - 1));
                default: r[c*NP +: NP] = NP'($urandom);
            endcase
        end
        return r;
    endfunction

    initial begin
        mh = '0;
        ml = '0;
        reset = 1'b1;
        a = '0;
        iv = 1'b0;
        ordy = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("post_reset.in_ready", 32'(bus_h.in_ready), 32'd1);

        // Basic translation, default build.
        a = {5'b00011, 5'b00100, 5'b01000, 5'b10000};
        iv = 1'b1;
        ordy = 1'b1;
        step();
        chk("basic.outSel", 32'(bus_h.outSel), 32'({3'd1, 3'd2, 3'd3, 3'd4}));
        chk("basic.multi_err", 32'(bus_h.multi_err), 32'(4'b1000));
        chk("basic.none_err", 32'(bus_h.none_err), 32'd0);
        chk("basic.conflict", 32'(bus_h.conflict), 32'd0);
        chk("basic.err_cnt", 32'(bus_h.err_cnt), 32'd1);

        // LSB-first priority.
        a = {5'b00000, 5'b00000, 5'b00000, 5'b00110};
        step();
        chk("lsb.ch0", 32'(bus_l.outSel[LW-1:0]), 32'd1);
        chk("lsb.multi0", 32'(bus_l.multi_err[0]), 32'd1);

        // Conflict with an empty channel in between.
        a = {5'b00001, 5'b00100, 5'b00000, 5'b00100};
        step();
        chk("conf.ch0", 32'(bus_h.outSel[LW-1:0]), 32'd2);
        chk("conf.ch2", 32'(bus_h.outSel[2*LW +: LW]), 32'd2);
        chk("conf.conflict", 32'(bus_h.conflict), 32'(4'b0100));
        chk("conf.none_err", 32'(bus_h.none_err), 32'(4'b0010));

        // Back-pressure, then drain and refill on the same edge.
        a = {5'b00010, 5'b00001, 5'b10000, 5'b01000};
        step();
        ordy = 1'b0;
        a = {5'b10000, 5'b01000, 5'b00100, 5'b00010};
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp.in_ready", 32'(bus_h.in_ready), 32'd0);
            chk("bp.outSel", 32'(bus_h.outSel), 32'({3'd1, 3'd0, 3'd4, 3'd3}));
        end
        ordy = 1'b1;
        step();
        chk("bp.refill", 32'(bus_h.outSel), 32'({3'd4, 3'd3, 3'd2, 3'd1}));
        chk("bp.valid", 32'(bus_h.out_valid), 32'd1);

        for (int k = 0; k < 400; k++) begin
            a = rand_alloc();
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Counter saturation from a preloaded near-full value.
        iv = 1'b0;
        ordy = 1'b1;
        mh = model_next(mh, 1'b1, reset, a, iv, ordy);
        ml = model_next(ml, 1'b0, reset, a, iv, ordy);
        force dut.err_cnt_q = 16'hFFFE;
        force dut_l.err_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.err_cnt_q;
        release dut_l.err_cnt_q;
        mh.cnt = 16'hFFFE;
        ml.cnt = 16'hFFFE;
        check_all();
        a = '0;
        iv = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("sat.err_cnt", 32'(bus_h.err_cnt), 32'hFFFF);
        step();
        chk("sat.hold", 32'(bus_l.err_cnt), 32'hFFFF);

        // Reset while a result is held under back-pressure.
        ordy = 1'b0;
        a = {5'b00001, 5'b00010, 5'b00100, 5'b01000};
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        iv = 1'b0;
        chk("rst.out_valid", 32'(bus_h.out_valid), 32'd0);
        chk("rst.err_cnt", 32'(bus_h.err_cnt), 32'd0);
        chk("rst.in_ready", 32'(bus_h.in_ready), 32'd1);
        step();
        iv = 1'b1;
        ordy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a = rand_alloc();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/out_sel_pipe.md
OUT_SEL_PIPE -- requirements
Module: out_sel_pipe

Interface
REQ-001 Parameter NUM_PORT, default 5, is the number of router output ports; legal range 2..16.
REQ-002 Parameter LOG_NUM_PORT, default 3, is the outSel field width; it SHALL be at least ceil(log2(NUM_PORT)).
REQ-003 Parameter NUM_CH, default 4, is the number of flit channels translated in parallel; legal range 1..8.
REQ-004 Parameter MSB_FIRST, default 1, selects the priority direction: 1 gives the highest set bit priority, 0 gives the lowest set bit priority.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 alloc  input  NUM_CH*NUM_PORT  per-channel allocation vectors; channel c occupies bits [c*NUM_PORT +: NUM_PORT].
REQ-008 in_valid  input  1  alloc is valid this cycle.
REQ-009 in_ready  output  1  the block accepts alloc this cycle.
REQ-010 outSel  output  NUM_CH*LOG_NUM_PORT  registered encoded port per channel; channel c occupies [c*LOG_NUM_PORT +: LOG_NUM_PORT].
REQ-011 out_valid  output  1  outSel and the flag outputs hold a result.
REQ-012 out_ready  input  1  the downstream consumer takes the result.
REQ-013 none_err  output  NUM_CH  per channel, the allocation vector was all-zero.
REQ-014 multi_err  output  NUM_CH  per channel, the allocation vector had more than one bit set.
REQ-015 conflict  output  NUM_CH  per channel, the encoded port equals that of a lower-indexed valid channel.
REQ-016 err_cnt  output  16  saturating count of accepted transfers that had any flag set.

Function
REQ-017 The block SHALL accept a transfer when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-018 An accepted transfer SHALL appear on outSel and the flag outputs with out_valid=1 exactly one cycle later (latency 1).
REQ-019 When out_valid=1 and out_ready=0, outSel, the flag outputs and out_valid SHALL hold unchanged.
REQ-020 When out_valid && out_ready and no new transfer is accepted, out_valid SHALL go to 0 on the next edge.
REQ-021 Simultaneous drain and accept SHALL load the new result and keep out_valid=1, giving full throughput.
REQ-022 The channel encoding SHALL be the index of the highest set bit when MSB_FIRST=1, and of the lowest set bit when MSB_FIRST=0.
REQ-023 An all-zero vector SHALL encode to 0 and set none_err[c]; multi_err[c] SHALL be 0 in that case.
REQ-024 multi_err[c] SHALL be set for 2 or more set bits; the priority encoding still applies.
REQ-025 conflict[c] SHALL be set if a channel j<c exists with none_err[j]=0, none_err[c]=0 and equal encodings; channel 0 never sets conflict.
REQ-026 err_cnt SHALL increment by 1 per accepted transfer with any none_err, multi_err or conflict bit set; it SHALL saturate at 16'hFFFF.
REQ-027 Alloc bits at or above NUM_PORT do not exist; the encoded value SHALL always be less than NUM_PORT.

Reset
REQ-028 While reset=1, the block SHALL set out_valid=0, outSel=0, none_err=0, multi_err=0, conflict=0 and err_cnt=0 on the edge.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 A transfer presented during a reset cycle SHALL be discarded, and a held result SHALL be lost on reset.

Verification
REQ-031 Defaults, NUM_CH=4; alloc ch0..3 = 10000, 01000, 00100, 00011; in_valid=1, out_ready=1 -> next cycle outSel = 4,3,2,1; multi_err=4'b1000; none_err=0; conflict=0; err_cnt=1.
REQ-032 MSB_FIRST=0; ch0=00110 -> outSel ch0=1, multi_err[0]=1.
REQ-033 ch0=00100, ch2=00100, ch1=00000 -> ch0=2, ch2=2; conflict=4'b0100; none_err=4'b0010 (plus channel 3 per its vector).
REQ-034 Back-pressure: out_ready=0 for 3 cycles after a result is loaded -> in_ready=0 and outputs stable; out_ready=1 with in_valid=1 -> the next result loads on the same edge with no bubble.
REQ-035 Force err_cnt to FFFE, then send 3 erroneous transfers -> err_cnt=FFFF and it holds there.
REQ-036 Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_cnt=0, in_ready=1.
